// File: rtl/mul_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: opcodes,
// FSM state encoding and small helpers used at elaboration and capture time.
package mul_div_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_MUL    = 3'b000;
    localparam op_t OP_MULH   = 3'b001;
    localparam op_t OP_MULHSU = 3'b010;
    localparam op_t OP_MULHU  = 3'b011;
    localparam op_t OP_DIV    = 3'b100;
    localparam op_t OP_DIVU   = 3'b101;
    localparam op_t OP_REM    = 3'b110;
    localparam op_t OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Counter width for n iterations; at least one bit so the counter always exists.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    function automatic logic op_is_div(input op_t op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input op_t op);
        return op[2] & op[1];
    endfunction

    function automatic logic op_a_signed(input op_t op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_b_signed(input op_t op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/mul_div_if.sv
// Request/response bundle between the pipeline hazard logic (master)
// and the multiply/divide unit (slave).
interface mul_div_if
    import mul_div_pkg::*;
#(
    parameter int DATA_W = 64
);
    logic              enable;
    logic              start;
    op_t               op;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic              kill;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;

    modport master (
        output enable, start, op, operand_a, operand_b, kill,
        input  busy, done, result
    );

    modport slave (
        input  enable, start, op, operand_a, operand_b, kill,
        output busy, done, result
    );
endinterface

// File: rtl/mul_div_step.sv
// One radix-2^BITS_PER_CYCLE iteration: shift-add for multiply, restoring
// trial-subtract for divide. acc holds {high/remainder, low/multiplier-or-quotient}.
module mul_div_step
    import mul_div_pkg::*;
#(
    parameter int DATA_W         = 64,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                  is_div,
    input  logic [2*DATA_W-1:0]   acc,
    input  logic [DATA_W-1:0]     operand,
    output logic [2*DATA_W-1:0]   acc_next
);

    logic [2*DATA_W-1:0] work;
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     trial;
    logic [DATA_W:0]     diff;

    always_comb begin
        work  = acc;
        sum   = '0;
        trial = '0;
        diff  = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (is_div) begin
                // Remainder shifted left with the next dividend bit; stays below 2*divisor.
                trial = work[2*DATA_W-1:DATA_W-1];
                diff  = trial - {1'b0, operand};
                if (trial >= {1'b0, operand}) begin
                    work = {diff[DATA_W-1:0], work[DATA_W-2:0], 1'b1};
                end else begin
                    work = {trial[DATA_W-1:0], work[DATA_W-2:0], 1'b0};
                end
            end else begin
                sum  = {1'b0, work[2*DATA_W-1:DATA_W]}
                     + (work[0] ? {1'b0, operand} : {(DATA_W+1){1'b0}});
                work = {sum, work[DATA_W-1:1]};
            end
        end
        acc_next = work;
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV64M multiply/divide unit with start/busy/done handshake,
// pipeline enable gating and flush; operands are handled as magnitudes.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int DATA_W         = 64,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic      clk,
    input  logic      arst,
    mul_div_if.slave  bus
);

    localparam int N     = DATA_W / BITS_PER_CYCLE;
    localparam int CNT_W = clog2(N);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N - 1);
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    state_t              state_reg;
    state_t              state_next;
    logic [CNT_W-1:0]    count_reg;
    logic [2*DATA_W-1:0] acc_reg;
    logic [2*DATA_W-1:0] acc_next;
    logic [DATA_W-1:0]   operand_reg;
    op_t                 op_reg;
    logic                sign_a_reg;
    logic                sign_b_reg;
    logic [DATA_W-1:0]   result_reg;

    logic                accept;
    logic                sign_a;
    logic                sign_b;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;
    logic                div_by_zero;
    logic                div_overflow;
    logic                special;
    logic [DATA_W-1:0]   special_result;
    logic [2*DATA_W-1:0] product_fixed;
    logic [DATA_W-1:0]   quotient;
    logic [DATA_W-1:0]   remainder;
    logic [DATA_W-1:0]   fixed_result;

    assign accept = bus.enable && bus.start && !bus.kill && (state_reg == ST_IDLE);

    // Capture-side decode: magnitudes and the divide cases that bypass CALC.
    assign sign_a = op_a_signed(bus.op) & bus.operand_a[DATA_W-1];
    assign sign_b = op_b_signed(bus.op) & bus.operand_b[DATA_W-1];
    assign mag_a  = sign_a ? -bus.operand_a : bus.operand_a;
    assign mag_b  = sign_b ? -bus.operand_b : bus.operand_b;

    assign div_by_zero  = op_is_div(bus.op) && (bus.operand_b == '0);
    assign div_overflow = op_is_div(bus.op) && !bus.op[0]
                          && (bus.operand_a == MOST_NEG) && (bus.operand_b == '1);
    assign special      = div_by_zero || div_overflow;

    always_comb begin
        special_result = '0;
        if (div_by_zero) begin
            special_result = op_is_rem(bus.op) ? bus.operand_a : '1;
        end else if (div_overflow) begin
            special_result = op_is_rem(bus.op) ? '0 : bus.operand_a;
        end
    end

    mul_div_step #(
        .DATA_W         (DATA_W),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .is_div   (op_is_div(op_reg)),
        .acc      (acc_reg),
        .operand  (operand_reg),
        .acc_next (acc_next)
    );

    // Sign correction and half/quotient/remainder selection for FIX.
    assign product_fixed = (sign_a_reg ^ sign_b_reg) ? -acc_reg : acc_reg;
    assign quotient      = acc_reg[DATA_W-1:0];
    assign remainder     = acc_reg[2*DATA_W-1:DATA_W];

    always_comb begin
        fixed_result = '0;
        unique case (op_reg)
            OP_MUL:                         fixed_result = product_fixed[DATA_W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   fixed_result = product_fixed[2*DATA_W-1:DATA_W];
            OP_DIV, OP_DIVU:                fixed_result = (sign_a_reg ^ sign_b_reg) ? -quotient : quotient;
            OP_REM, OP_REMU:                fixed_result = sign_a_reg ? -remainder : remainder;
            default:                        fixed_result = '0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = special ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (bus.kill) begin
                    state_next = ST_IDLE;
                end else if (count_reg == CNT_LAST) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX:  state_next = bus.kill ? ST_IDLE : ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_reg <= ST_IDLE;
        end else if (bus.enable) begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            count_reg   <= '0;
            acc_reg     <= '0;
            operand_reg <= '0;
            op_reg      <= OP_MUL;
            sign_a_reg  <= 1'b0;
            sign_b_reg  <= 1'b0;
            result_reg  <= '0;
        end else if (bus.enable) begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        op_reg     <= bus.op;
                        sign_a_reg <= sign_a;
                        sign_b_reg <= sign_b;
                        count_reg  <= '0;
                        // Multiply: multiplier in the low half, multiplicand added in.
                        // Divide: dividend in the low half, divisor subtracted.
                        if (op_is_div(bus.op)) begin
                            operand_reg <= mag_b;
                            acc_reg     <= {{DATA_W{1'b0}}, mag_a};
                        end else begin
                            operand_reg <= mag_a;
                            acc_reg     <= {{DATA_W{1'b0}}, mag_b};
                        end
                        if (special) begin
                            result_reg <= special_result;
                        end
                    end
                end
                ST_CALC: begin
                    if (bus.kill || (count_reg == CNT_LAST)) begin
                        count_reg <= '0;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                    if (!bus.kill) begin
                        acc_reg <= acc_next;
                    end
                end
                ST_FIX: begin
                    if (!bus.kill) begin
                        result_reg <= fixed_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy   = (state_reg == ST_CALC) || (state_reg == ST_FIX);
    assign bus.done   = (state_reg == ST_DONE);
    assign bus.result = result_reg;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multi-cycle integer multiply/divide unit for the EX stage of the pipelined RISC-V core.
- Implements all eight RV64M operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Uses a start/busy/done handshake so the hazard logic can stall IF/ID/EX while it runs.
- Is generalised in data width and radix (bits retired per cycle). Honours the global pipeline enable and a flush (kill) input.

Parameters:
- DATA_W, 64: operand and result width. Must be a power of two, >= 8.
- BITS_PER_CYCLE, 1: quotient/multiplier bits processed per CALC cycle. Must divide DATA_W; allowed values 1, 2, 4.

Ports:
- clk  in  1  main clock, rising edge.
- arst  in  1  asynchronous reset, active-high.
- enable  in  1  global run enable. Low freezes all state, including the counter.
- start  in  1  request a new operation. Accepted only in IDLE with enable=1 and kill=0.
- op  in  3  RISC-V M-extension func3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_a  in  DATA_W  rs1 value; multiplicand or dividend. Captured on start.
- operand_b  in  DATA_W  rs2 value; multiplier or divisor. Captured on start.
- kill  in  1  flush. Aborts any operation in flight.
- busy  out  1  high in CALC and FIX.
- done  out  1  one-cycle pulse; result is valid in the same cycle.
- result  out  DATA_W  last completed result. Held until the next done.

Behaviour:
- Clock and reset: one clock, clk. arst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, counter=0, all internal operand registers 0.
- Gating: every register updates only when enable=1. arst overrides enable.
- N = DATA_W/BITS_PER_CYCLE.
- States and transitions:
  - IDLE -> CALC on accepted start. Operands and op are latched at this point.
  - IDLE -> DONE instead, for divide special cases. They skip CALC and FIX.
  - CALC: runs exactly N enabled cycles, with the counter counting 0..N-1, then -> FIX.
  - FIX: applies sign correction and selects the high/low half or quotient/remainder, then -> DONE.
  - DONE: done=1 and result updated for exactly one cycle, then -> IDLE. A start in the DONE cycle is ignored.
- Latency: start accepted at edge 0 gives done high in cycle N+2 (66 for the defaults). Divide special cases give done in cycle 1. Every enable-low cycle adds one cycle.
- Signed handling:
  - Signed operands are converted to magnitudes on capture.
  - MULHSU treats operand_a as signed and operand_b as unsigned.
  - Product is computed at 2*DATA_W bits, then negated in FIX if the operand signs differ.
  - Quotient is negated if the signs differ. Remainder takes the sign of the dividend.
- Multiply algorithm: shift-add, BITS_PER_CYCLE partial products per cycle.
  - MUL returns product[DATA_W-1:0].
  - MULH, MULHSU and MULHU return product[2*DATA_W-1:DATA_W].
- Divide algorithm: restoring division, BITS_PER_CYCLE quotient bits per cycle.
- Divide special cases, resolved at capture:
  - Divisor 0: quotient = all ones; remainder = operand_a, unmodified.
  - Signed overflow (operand_a = most-negative and operand_b = -1, DIV/REM only): quotient = operand_a; remainder = 0.
- kill:
  - Synchronous. State -> IDLE at the next enabled edge.
  - busy drops at that edge. No done pulse. result is unchanged.
  - kill and start in the same cycle: kill wins and start is dropped.
  - kill in DONE: the done pulse already in progress completes normally.
- start while busy is ignored. The caller must hold the instruction in EX until done.
- No exceptions are raised; overflow and divide-by-zero results follow the RISC-V specification.

Decomposition:
- Shared package mul_div_pkg holds:
  - op localparams: OP_MUL..OP_REMU.
  - state encoding: ST_IDLE, ST_CALC, ST_FIX, ST_DONE.
  - helper constant function for the counter width, clog2(N).
- One sub-module is natural: mul_div_step. It is purely combinational and performs one radix-2^BITS_PER_CYCLE iteration: add/shift for multiply, trial-subtract/shift for divide. It is instantiated once and fed from the state registers.
- FSM, counter and sign fix-up live in mul_div_unit.

Test Plan:
- MUL 7 * -3 (0xFFFF_FFFF_FFFF_FFFD), defaults -> done exactly 66 cycles after start; result 0xFFFF_FFFF_FFFF_FFEB; busy high for cycles 1..65.
- MULHU 0xFFFF_FFFF_FFFF_FFFF * 2 -> result 0x1. MULH -1 * -1 -> 0x0. MULHSU -1 * 2 -> 0xFFFF_FFFF_FFFF_FFFF.
- DIV -20 / 3 -> 0xFFFF_FFFF_FFFF_FFFA (-6). REM -20 / 3 -> 0xFFFF_FFFF_FFFF_FFFE (-2). DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- Special cases:
  - DIVU 5 / 0 -> all ones; REMU 5 / 0 -> 5.
  - DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM of the same operands -> 0.
  - All four: done exactly 1 cycle after start.
- MUL 3 * 4, kill in CALC cycle 10 -> busy low next cycle, no done, result keeps its prior value. A new MUL 3 * 4 then yields 12. enable held low for 5 mid-CALC cycles -> done at cycle 71.
- BITS_PER_CYCLE=4, DATA_W=32: DIV -7 / 2 -> 0xFFFF_FFFD with done at cycle 10. arst pulsed mid-operation -> busy=0, done=0, result=0 immediately, without waiting for a clock edge.
